// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator: FSM encoding and the
// constant that replaces an all-zero seed.
package lfsr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Zero is the one state a Galois LFSR can never leave, so it is never loaded.
  localparam logic [31:0] LOCKUP_SEED = 32'h0000_0001;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and stream bundle of the LFSR generator. The controller/consumer
// side is the master; lfsr_gen is the slave.
interface lfsr_gen_if #(
  parameter int WIDTH = 16
);

  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] tap;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             period_valid;

  modport master (
    output load, seed, tap, out_ready,
    input  out_valid, out_data, wrap, period, period_valid
  );

  modport slave (
    input  load, seed, tap, out_ready,
    output out_valid, out_data, wrap, period, period_valid
  );

endinterface

// File: rtl/lfsr_step.sv
// One Galois LFSR step: shift right and, if the bit shifted out was set,
// toggle the state with the tap mask.
module lfsr_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] next
);

  assign next = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? tap : {WIDTH{1'b0}});

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR stream source with valid/ready output, advancing STEPS steps
// per accepted transfer, and measuring the sequence period up to the first wrap.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEPS = 1
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_TAP   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] RESET_TAP = {2'b11, {(WIDTH-2){1'b0}}};

  fsm_state_t       fsm_r;
  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] tap_r;
  logic [WIDTH-1:0] cnt_r;
  logic             valid_r;
  logic             wrap_r;
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;

  logic [WIDTH-1:0] seed_fix_s;
  logic [WIDTH-1:0] tap_fix_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic             xfer_s;
  logic [WIDTH-1:0] chain_s [STEPS+1];

  assign seed_fix_s = (bus.seed == {WIDTH{1'b0}}) ? LOCKUP_SEED[WIDTH-1:0] : bus.seed;
  assign tap_fix_s  = bus.tap | MSB_TAP;
  assign cnt_inc_s  = (cnt_r == ALL_ONES) ? ALL_ONES : (cnt_r + ONE);
  assign xfer_s     = valid_r & bus.out_ready;

  // STEPS single-step stages chained so one transfer advances a whole group.
  assign chain_s[0] = state_r;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH)) u_step (
      .state (chain_s[g]),
      .tap   (tap_r),
      .next  (chain_s[g+1])
    );
  end

  // Control FSM, LFSR state, transfer counter and period measurement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_r          <= IDLE;
      state_r        <= LOCKUP_SEED[WIDTH-1:0];
      start_r        <= LOCKUP_SEED[WIDTH-1:0];
      tap_r          <= RESET_TAP;
      cnt_r          <= {WIDTH{1'b0}};
      valid_r        <= 1'b0;
      wrap_r         <= 1'b0;
      period_r       <= {WIDTH{1'b0}};
      period_valid_r <= 1'b0;
    end else if (bus.load) begin
      // Load wins over a simultaneous transfer: the old word is consumed, the seed replaces it.
      fsm_r          <= RUN;
      state_r        <= seed_fix_s;
      start_r        <= seed_fix_s;
      tap_r          <= tap_fix_s;
      cnt_r          <= {WIDTH{1'b0}};
      valid_r        <= 1'b1;
      wrap_r         <= 1'b0;
      period_r       <= {WIDTH{1'b0}};
      period_valid_r <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          valid_r <= 1'b0;
          wrap_r  <= 1'b0;
        end
        RUN: begin
          valid_r <= 1'b1;
          if (xfer_s) begin
            state_r <= chain_s[STEPS];
            cnt_r   <= cnt_inc_s;
            if (chain_s[STEPS] == start_r) begin
              wrap_r <= 1'b1;
              if (!period_valid_r) begin
                period_r       <= cnt_inc_s;
                period_valid_r <= 1'b1;
              end else begin
                period_r       <= period_r;
                period_valid_r <= period_valid_r;
              end
            end else begin
              wrap_r <= 1'b0;
            end
          end else begin
            wrap_r <= 1'b0;
          end
        end
        default: begin
          fsm_r   <= IDLE;
          valid_r <= 1'b0;
          wrap_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid    = valid_r;
  assign bus.out_data     = state_r;
  assign bus.wrap         = wrap_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, LFSR length in bits (legal 3..32).
REQ-002 SHALL have parameter STEPS, default 1, single-bit LFSR steps advanced per accepted transfer (legal 1..WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  one-cycle request to (re)start from seed.
REQ-006 SHALL have port seed  input  WIDTH  start state, sampled when load=1.
REQ-007 SHALL have port tap  input  WIDTH  Galois toggle mask, sampled when load=1.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid LFSR state.
REQ-010 SHALL have port out_data  output  WIDTH  current LFSR state.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse: sequence returned to its start state.
REQ-012 SHALL have port period  output  WIDTH  transfers counted from start to first wrap.
REQ-013 SHALL have port period_valid  output  1  period holds a measured value.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (out_valid=0) and RUN (out_valid=1).
REQ-015 SHALL, on load=1 in any state, set state to seed, set start register to seed, latch effective tap, clear transfer counter, period and period_valid, and enter RUN on the next cycle.
REQ-016 SHALL replace an all-zero seed with 1 (lock-up avoidance), for both state and start register.
REQ-017 SHALL force effective tap bit WIDTH-1 to 1 whatever the tap input.
REQ-018 SHALL define one step as: fb = state[0]; next = (state >> 1) XOR (fb ? eff_tap : 0).
REQ-019 SHALL, on transfer (out_valid && out_ready, load=0), advance state by STEPS steps in that same edge; out_data stays stable while out_ready=0.
REQ-020 SHALL increment the transfer counter (WIDTH bits, saturating at all-ones) on every transfer.
REQ-021 SHALL, when a transfer yields next state equal to the start register and period_valid=0, pulse wrap for one cycle, latch period = counter+1 (saturated), and set period_valid.
REQ-022 SHALL pulse wrap on every later return to the start state, leaving period unchanged.
REQ-023 SHALL give load priority over a simultaneous transfer: the transfer of the old out_data completes but the new state is seed; no wrap, no counter increment.
REQ-024 SHALL ignore out_ready in IDLE; state does not change there.
REQ-025 SHALL produce out_data with zero combinational path from inputs (registered output).

Reset
REQ-026 SHALL, while rst=0, immediately force: FSM IDLE, state=1, start register=1, eff_tap=bit WIDTH-1 only plus bit WIDTH-2, counter=0, out_valid=0, wrap=0, period=0, period_valid=0.
REQ-027 SHALL abort any run on reset assertion mid-operation; after release it waits in IDLE for load.
REQ-028 SHALL resume normal operation on the first clk edge after rst returns high.

Structure
REQ-029 SHALL place FSM state encoding (IDLE, RUN) and the lock-up replacement constant in shared package lfsr_pkg.
REQ-030 SHALL implement the single-step function as combinational sub-module lfsr_step (WIDTH parameter, state/tap in, next out), instantiated STEPS times in a chain.

Verification
REQ-031 SHALL test WIDTH=4, STEPS=1, tap=4'hC, seed=4'h1, out_ready=1 -> out_data 1,C,6,3,D,...; wrap pulses on the 15th transfer, period=15, period_valid=1.
REQ-032 SHALL test seed=4'h0, tap=4'h4 -> out_data=1 after load; sequence identical to REQ-031 (zero seed and missing MSB tap corrected).
REQ-033 SHALL test WIDTH=4, STEPS=2, tap=4'hC, seed=1 -> out_data 1,6,D,...; wrap after 15 transfers; period=15.
REQ-034 SHALL test out_ready low for 5 cycles in RUN -> out_data and counter frozen; first transfer after out_ready high advances exactly one STEPS group.
REQ-035 SHALL test load with out_ready=1 on transfer 7 (seed=4'h8) -> next out_data=8, counter=0, no wrap; rst low mid-run -> out_valid=0 and out_data=1 immediately, without a clk edge.
